// File: rtl/j1_uart.sv
// j1_uart: memory-mapped UART for the J1 CPU. 4-deep TX FIFO feeding a serial
// shifter, single-byte RX holding register with overrun and framing status.
//
// state | meaning (shared by the TX and RX FSMs)
// IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// START | start bit
// DATA  | eight data bits, LSB first
// STOP  | stop bit
module j1_uart #(
  parameter int CLKDIV = 217
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_tx,
  input  logic        uart_rx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKDIV / 2 - 1);

  logic sel_data, sel_stat, wr_data, rd_pop, rd_stat;
  logic unused_io_bits;

  assign sel_data       = io_addr[12];
  assign sel_stat       = io_addr[13];
  assign wr_data        = io_wr & sel_data;
  assign rd_pop         = io_rd & sel_data;
  assign rd_stat        = io_rd & sel_stat;
  assign unused_io_bits = ^{io_addr[15:14], io_addr[11:0], io_dout[15:8]};

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign push       = wr_data & ~fifo_full;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= io_dout[7:0];

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end

  state_t      tx_state, tx_state_nxt;
  logic [15:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]  tx_idx, tx_idx_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic        tx_tc, tx_bit_nxt, tx_idle;

  assign tx_tc   = (tx_cnt == 16'd0);
  assign tx_idle = (tx_state == S_IDLE) & fifo_empty;

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_idx   <= tx_idx_nxt;
      tx_shift <= tx_shift_nxt;
      uart_tx  <= tx_bit_nxt;
    end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_tc ? 16'd0 : tx_cnt - 16'd1;
    tx_idx_nxt   = tx_idx;
    tx_shift_nxt = tx_shift;
    pop          = 1'b0;
    unique case (tx_state)
      S_IDLE:
        if (!fifo_empty) begin
          tx_state_nxt = S_START;
          tx_cnt_nxt   = BIT_LAST;
          tx_shift_nxt = fifo_mem[rd_ptr];
          pop          = 1'b1;
        end
      S_START:
        if (tx_tc) begin
          tx_state_nxt = S_DATA;
          tx_cnt_nxt   = BIT_LAST;
          tx_idx_nxt   = 3'd0;
        end
      S_DATA:
        if (tx_tc) begin
          tx_cnt_nxt = BIT_LAST;
          tx_idx_nxt = tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state_nxt = S_STOP;
        end
      S_STOP:
        if (tx_tc) begin
          if (!fifo_empty) begin
            tx_state_nxt = S_START;
            tx_cnt_nxt   = BIT_LAST;
            tx_shift_nxt = fifo_mem[rd_ptr];
            pop          = 1'b1;
          end else begin
            tx_state_nxt = S_IDLE;
          end
        end
    endcase
  end

  // Line level is registered from the next state so it switches with the FSM.
  always_comb begin
    tx_bit_nxt = 1'b1;
    case (tx_state_nxt)
      S_START: tx_bit_nxt = 1'b0;
      S_DATA:  tx_bit_nxt = tx_shift_nxt[tx_idx_nxt];
      default: tx_bit_nxt = 1'b1;
    endcase
  end

  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
    end

  state_t      rx_state, rx_state_nxt;
  logic [15:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]  rx_idx, rx_idx_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        rx_tc, rx_done_ok, rx_done_err;

  assign rx_tc = (rx_cnt == 16'd0);

  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_shift <= rx_shift_nxt;
    end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_tc ? 16'd0 : rx_cnt - 16'd1;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    unique case (rx_state)
      S_IDLE:
        if (rx_prev & ~rx_s) begin
          rx_state_nxt = S_START;
          rx_cnt_nxt   = HALF_LAST;
        end
      S_START:
        if (rx_tc) begin
          if (rx_s) begin
            rx_state_nxt = S_IDLE;
          end else begin
            rx_state_nxt = S_DATA;
            rx_cnt_nxt   = BIT_LAST;
            rx_idx_nxt   = 3'd0;
          end
        end
      S_DATA:
        if (rx_tc) begin
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          rx_cnt_nxt   = BIT_LAST;
          rx_idx_nxt   = rx_idx + 3'd1;
          if (rx_idx == 3'd7) rx_state_nxt = S_STOP;
        end
      S_STOP:
        if (rx_tc) rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    if (rx_state == S_STOP && rx_tc) begin
      rx_done_ok  = rx_s;
      rx_done_err = ~rx_s;
    end
  end

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_overrun, rx_frame_err;
  logic [15:0] status;

  assign status = {11'd0, rx_frame_err, tx_idle, rx_overrun, rx_valid, fifo_full};

  // A frame landing on the same cycle as a DATA read counts as the read
  // having emptied the buffer first, so no overrun is flagged.
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) begin
      rx_byte      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      io_din       <= 16'd0;
    end else begin
      if (rx_done_ok) begin
        rx_byte    <= rx_shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rd_pop ? 1'b0 : (rx_overrun | rx_valid);
      end else if (rd_pop) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (rx_done_err)  rx_frame_err <= 1'b1;
      else if (rd_stat) rx_frame_err <= 1'b0;
      if (io_rd) io_din <= sel_stat ? status : (sel_data ? {8'h00, rx_byte} : 16'h0000);
    end
endmodule

// File: tb/tb_j1_uart.sv
// Directed bench for j1_uart at CLKDIV=16: register access, TX framing and FIFO,
// RX with overrun/framing errors, glitch rejection and reset mid-frame.
module tb_j1_uart;
  localparam int CLKDIV = 16;
  // Extra address bits set to show they are ignored by the decode.
  localparam logic [15:0] A_DATA = 16'h9001;
  localparam logic [15:0] A_STAT = 16'h6002;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_wr = 1'b0;
  logic        io_rd = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  j1_uart #(.CLKDIV(CLKDIV)) dut (
    .clk(clk), .resetq(resetq), .io_wr(io_wr), .io_rd(io_rd),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  task automatic io_write(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    io_addr = addr; io_dout = data; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [15:0] d);
    @(negedge clk);
    io_addr = addr; io_rd = 1'b1;
    @(negedge clk);
    io_rd = 1'b0;
    d = io_din;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLKDIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Decodes one frame off uart_tx by sampling mid-bit after the falling edge.
  task automatic tx_capture(output logic [7:0] b, output logic stop_bit,
                            output int t_start, output logic ok);
    ok = 1'b0; b = 8'h00; stop_bit = 1'b0; t_start = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        t_start = cyc;
      end
    end
    if (ok) begin
      repeat (CLKDIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLKDIV) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CLKDIV) @(negedge clk);
      stop_bit = uart_tx;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    resetq = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++;
    if (io_din !== 16'h0000) begin errors++; $display("FAIL reset_io_din: got %h want 0000", io_din); end
    resetq = 1'b1;
    repeat (2) @(negedge clk);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL reset_status: got %h want 0008", d); end
  endtask

  task automatic test_tx_single();
    logic [7:0]  b;
    logic        exp;
    logic [15:0] d;
    b = 8'h55;
    @(negedge clk);
    io_addr = A_DATA; io_dout = 16'h0055; io_wr = 1'b1;
    @(negedge clk);
    io_wr = 1'b0;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_pre_start: got %b want 1", uart_tx); end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      checks++;
      if (uart_tx !== exp) begin errors++; $display("FAIL tx_bit%0d_first: got %b want %b", k, uart_tx, exp); end
      repeat (CLKDIV - 1) @(negedge clk);
      checks++;
      if (uart_tx !== exp) begin errors++; $display("FAIL tx_bit%0d_last: got %b want %b", k, uart_tx, exp); end
      @(negedge clk);
    end
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_after_stop: got %b want 1", uart_tx); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL tx_idle_status: got %h want 0008", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] st;
    logic [7:0]  b;
    logic        stop_bit, ok;
    int          t_start, t_prev, lows;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          io_addr = A_DATA; io_dout = 16'(i + 1); io_wr = 1'b1;
        end
        @(negedge clk);
        io_wr = 1'b0;
        io_read(A_STAT, st);
        checks++;
        if (st !== 16'h0001) begin errors++; $display("FAIL b2b_full_status: got %h want 0001", st); end
      end
      begin
        t_prev = 0;
        for (int f = 0; f < 5; f++) begin
          tx_capture(b, stop_bit, t_start, ok);
          checks++;
          if (!ok) begin
            errors++; $display("FAIL b2b_frame%0d_timeout: no start bit seen, want one", f);
            break;
          end
          if (b !== 8'(f + 1)) begin errors++; $display("FAIL b2b_frame%0d_byte: got %h want %h", f, b, 8'(f + 1)); end
          checks++;
          if (stop_bit !== 1'b1) begin errors++; $display("FAIL b2b_frame%0d_stop: got %b want 1", f, stop_bit); end
          if (f > 0) begin
            checks++;
            if (t_start - t_prev !== 10 * CLKDIV) begin
              errors++; $display("FAIL b2b_frame%0d_gap: got %0d cycles want %0d", f, t_start - t_prev, 10 * CLKDIV);
            end
          end
          t_prev = t_start;
        end
      end
    join
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL b2b_sixth_dropped: got %0d low cycles want 0", lows); end
    io_read(A_STAT, st);
    checks++;
    if (st !== 16'h0008) begin errors++; $display("FAIL b2b_final_status: got %h want 0008", st); end
  endtask

  // Expected STATUS values below include bit3 (tx_idle), since TX is idle.
  task automatic test_rx_single();
    logic [15:0] d;
    send_frame(8'hA3, 1'b1);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h000A) begin errors++; $display("FAIL rx_valid_status: got %h want 000a", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h00A3) begin errors++; $display("FAIL rx_data: got %h want 00a3", d); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL rx_cleared_status: got %h want 0008", d); end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] d;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h000E) begin errors++; $display("FAIL ovr_status: got %h want 000e", d); end
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h0022) begin errors++; $display("FAIL ovr_data: got %h want 0022", d); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL ovr_cleared_status: got %h want 0008", d); end
  endtask

  task automatic test_rx_frame_err();
    logic [15:0] d;
    send_frame(8'h5A, 1'b0);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0018) begin errors++; $display("FAIL ferr_status: got %h want 0018", d); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL ferr_cleared_status: got %h want 0008", d); end
  endtask

  task automatic test_rx_glitch();
    logic [15:0] d;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLKDIV / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL glitch_status: got %h want 0008", d); end
    send_frame(8'h3C, 1'b1);
    io_read(A_DATA, d);
    checks++;
    if (d !== 16'h003C) begin errors++; $display("FAIL glitch_recover_data: got %h want 003c", d); end
  endtask

  task automatic test_reset_mid_tx();
    logic [15:0] d;
    int lows;
    io_write(A_DATA, 16'h0000);
    io_write(A_DATA, 16'h00FF);
    repeat (40) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b0) begin errors++; $display("FAIL rst_tx_mid_frame: got %b want 0", uart_tx); end
    #2 resetq = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx_async: got %b want 1", uart_tx); end
    checks++;
    if (io_din !== 16'h0000) begin errors++; $display("FAIL rst_io_din_async: got %h want 0000", io_din); end
    repeat (3) @(negedge clk);
    resetq = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL rst_queue_lost: got %0d low cycles want 0", lows); end
    io_read(A_STAT, d);
    checks++;
    if (d !== 16'h0008) begin errors++; $display("FAIL rst_status: got %h want 0008", d); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_rx_frame_err();
    test_rx_glitch();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
